// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer.
//   op_e    : 2-bit operation code carried on cmd_op
//   state_e : sequencer FSM state
package alu_pkg;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpOr  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAccum = 2'b01,
        StDone  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 8-bit operator.
// Ports:
//   op  : operation code (see alu_pkg::op_e)
//   a   : left operand (accumulator)
//   b   : right operand (incoming beat data)
//   out : result, modulo 256 for add/sub, bitwise for and/or
module alu_core
    import alu_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        unique case (op_e'(op))
            OpAdd: out = a + b;
            OpSub: out = a - b;
            OpAnd: out = a & b;
            OpOr:  out = a | b;
            default: out = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Packet accumulator: the first beat of a packet loads the accumulator, each
// later beat folds its operand in with the selected operation, and the result
// is presented with a saturating beat count once the last beat is taken.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            : command beat handshake
//   cmd_op, cmd_data, cmd_last     : beat operation, operand, end-of-packet
//   res_valid/res_ready            : result handshake
//   res_data, res_count            : accumulated value, beat count
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [CNT_W-1:0] res_count
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state;
    logic [7:0]       acc;
    logic [CNT_W-1:0] count;
    logic [7:0]       alu_out;

    alu_core u_alu_core (
        .op  (cmd_op),
        .a   (acc),
        .b   (cmd_data),
        .out (alu_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            acc   <= 8'h00;
            count <= '0;
        end else begin
            case (state)
                StIdle: begin
                    // First beat: operand loads directly, cmd_op is ignored
                    if (cmd_valid) begin
                        acc   <= cmd_data;
                        count <= CntOne;
                        state <= cmd_last ? StDone : StAccum;
                    end
                end
                StAccum: begin
                    if (cmd_valid) begin
                        acc <= alu_out;
                        if (count != CntMax) begin
                            count <= count + CntOne;
                        end
                        if (cmd_last) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    // acc/count held until the result is taken
                    if (res_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign cmd_ready = (state != StDone);
    assign res_valid = (state == StDone);
    assign res_data  = acc;
    assign res_count = count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer. Inputs change on the falling
// edge; outputs are sampled on the falling edge, away from the rising edge.
module tb_alu_sequencer;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [7:0]       cmd_data;
    logic             cmd_last;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic [CNT_W-1:0] res_count;

    int n_checks;
    int n_pass;

    alu_sequencer #(
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_last  (cmd_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_count (res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one beat; it is expected to be accepted on the next rising edge.
    task automatic send_beat(input logic [1:0] op, input logic [7:0] data, input logic last);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_last  = last;
        check_eq("beat_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
    endtask

    // Called right after the last beat's edge with res_ready = 1: result
    // must show on the next cycle and last exactly one cycle.
    task automatic check_result(input string tag, input logic [7:0] data,
                                input logic [CNT_W-1:0] cnt);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        check_eq({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, res_data}, {24'd0, data});
        check_eq({tag, "_count"}, {28'd0, res_count}, {28'd0, cnt});
        check_eq({tag, "_busy"}, {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_drop"}, {31'd0, res_valid}, 32'd0);
        check_eq({tag, "_rdy"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rdy"}, {31'd0, cmd_ready}, 32'd1);
        check_eq({tag, "_valid"}, {31'd0, res_valid}, 32'd0);
        check_eq({tag, "_data"}, {24'd0, res_data}, 32'd0);
        check_eq({tag, "_count"}, {28'd0, res_count}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        cmd_last  = 1'b0;
        res_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;

        // 10, add 5, sub 3 -> 12; idle gaps with garbage inputs in between
        send_beat(2'b11, 8'd10, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'hFF;
        cmd_op    = 2'b10;
        cmd_last  = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("gap_rdy", {31'd0, cmd_ready}, 32'd1);
        check_eq("gap_acc", {24'd0, res_data}, 32'd10);
        check_eq("gap_cnt", {28'd0, res_count}, 32'd1);
        send_beat(2'b00, 8'd5, 1'b0);
        send_beat(2'b01, 8'd3, 1'b1);
        check_result("basic", 8'd12, 4'd3);

        // Wrap-around add and sub
        send_beat(2'b00, 8'hF0, 1'b0);
        send_beat(2'b00, 8'h20, 1'b1);
        check_result("wrap_add", 8'h10, 4'd2);
        send_beat(2'b00, 8'h05, 1'b0);
        send_beat(2'b01, 8'h07, 1'b1);
        check_result("wrap_sub", 8'hFE, 4'd2);

        // Bitwise ops and single-beat packet (op on first beat ignored)
        send_beat(2'b10, 8'hF0, 1'b0);
        send_beat(2'b11, 8'h0F, 1'b0);
        send_beat(2'b10, 8'h3C, 1'b1);
        check_result("bitwise", 8'h3C, 4'd3);
        send_beat(2'b01, 8'hAA, 1'b1);
        check_result("single", 8'hAA, 4'd1);

        // Back-pressure: result held, no beat accepted while cmd_valid stays high
        res_ready = 1'b0;
        send_beat(2'b00, 8'h33, 1'b0);
        send_beat(2'b00, 8'h11, 1'b1);
        @(negedge clk);
        cmd_data = 8'h99;
        cmd_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", {31'd0, res_valid}, 32'd1);
            check_eq("hold_rdy", {31'd0, cmd_ready}, 32'd0);
            check_eq("hold_data", {24'd0, res_data}, 32'h44);
            check_eq("hold_cnt", {28'd0, res_count}, 32'd2);
            @(negedge clk);
        end
        check_eq("hold_end", {31'd0, res_valid}, 32'd1);
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check_eq("hold_rel", {31'd0, res_valid}, 32'd0);
        check_eq("hold_acc", {24'd0, res_data}, 32'h44);

        // 20-beat packet: 0 then 19 x add 1 -> 19, count saturates at 15
        send_beat(2'b00, 8'd0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            send_beat(2'b00, 8'd1, 1'b0);
        end
        send_beat(2'b00, 8'd1, 1'b1);
        check_result("sat", 8'd19, 4'd15);

        // Reset mid-packet discards the partial packet
        send_beat(2'b00, 8'h50, 1'b0);
        send_beat(2'b00, 8'h22, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        check_reset_outputs("rst_mid2");
        rst = 1'b0;
        send_beat(2'b00, 8'd7, 1'b0);
        send_beat(2'b00, 8'd1, 1'b1);
        check_result("post_rst", 8'd8, 4'd2);

        // Reset while holding an undelivered result
        res_ready = 1'b0;
        send_beat(2'b00, 8'h40, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("done_valid", {31'd0, res_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_done");
        @(negedge clk);
        rst       = 1'b0;
        res_ready = 1'b1;
        send_beat(2'b00, 8'h01, 1'b0);
        send_beat(2'b11, 8'h80, 1'b1);
        check_result("post_rst2", 8'h81, 4'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
